selector_consigna: RTL and testbench

//  Setpoint memory feeding the 7-segment display encoder and the DPWM core.

---
 rtl/selector_consigna.sv | 146 ++++++++++++++
 tb/tb_selector_consigna.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/selector_consigna.sv
// Setpoint selector: debounces up/down/mode pushbuttons and steps frequency/current tables.
// Define SEL_WRAP_EN to make stepping wrap around the table ends instead of saturating.
module selector_consigna #(
   parameter int DEB_W   = 20,
   parameter int DEB_MAX = 500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_mode,
   output logic [7:0] frecuencia,
   output logic [9:0] corriente,
   output logic       control,
   output logic       cambio
);

   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_MAX - 1);
   localparam logic [4:0]       F_MAX    = 5'd9;
   localparam logic [4:0]       C_MAX    = 5'd20;

   // Button vectors are ordered {mode, down, up}.
   logic [2:0]             sync1_q, sync1_d;
   logic [2:0]             sync2_q, sync2_d;
   logic [2:0]             stable_q, stable_d;
   logic [2:0]             press_q, press_d;
   logic [2:0][DEB_W-1:0]  cnt_q, cnt_d;
   logic [4:0]             idx_f_q, idx_f_d;
   logic [4:0]             idx_c_q, idx_c_d;
   logic                   control_q, control_d;
   logic [7:0]             frecuencia_q, frecuencia_d;
   logic [9:0]             corriente_q, corriente_d;
   logic                   cambio_q, cambio_d;

   function automatic logic [7:0] freq_lut(input logic [4:0] idx);
      logic [7:0] f;
      case (idx)
         5'd1:    f = 8'd30;
         5'd2:    f = 8'd50;
         5'd3:    f = 8'd75;
         5'd4:    f = 8'd100;
         5'd5:    f = 8'd125;
         5'd6:    f = 8'd150;
         5'd7:    f = 8'd175;
         5'd8:    f = 8'd200;
         5'd9:    f = 8'd250;
         default: f = 8'd0;
      endcase
      return f;
   endfunction

   // 50*idx as a sum of shifts: 32+16+2.
   function automatic logic [9:0] curr_calc(input logic [4:0] idx);
      logic [9:0] w;
      w = {5'd0, idx};
      return (w << 5) + (w << 4) + (w << 1);
   endfunction

   function automatic logic [4:0] step_idx(input logic [4:0] idx, input logic [4:0] max_idx,
                                           input logic up);
      logic [4:0] r;
      if (up) begin
`ifdef SEL_WRAP_EN
         r = (idx == max_idx) ? 5'd0 : idx + 5'd1;
`else
         r = (idx == max_idx) ? idx : idx + 5'd1;
`endif
      end else begin
`ifdef SEL_WRAP_EN
         r = (idx == 5'd0) ? max_idx : idx - 5'd1;
`else
         r = (idx == 5'd0) ? idx : idx - 5'd1;
`endif
      end
      return r;
   endfunction

   // NOTE: every _d gets a default before any branch so no latch is inferred.
   always_comb begin
      sync1_d  = {btn_mode, btn_down, btn_up};
      sync2_d  = sync1_q;
      stable_d = stable_q;
      press_d  = 3'b000;
      cnt_d    = cnt_q;
      for (int b = 0; b < 3; b++) begin
         if (sync2_q[b] == stable_q[b]) begin
            cnt_d[b] = '0;
         end else if (cnt_q[b] == DEB_LAST) begin
            stable_d[b] = sync2_q[b];
            press_d[b]  = sync2_q[b];
            cnt_d[b]    = '0;
         end else begin
            cnt_d[b] = cnt_q[b] + DEB_W'(1);
         end
      end
   end

   // Step decision uses the pre-toggle mode, so a simultaneous mode press still steps.
   always_comb begin
      idx_f_d   = idx_f_q;
      idx_c_d   = idx_c_q;
      control_d = control_q ^ press_q[2];
      if (press_q[0] ^ press_q[1]) begin
         if (control_q) idx_f_d = step_idx(idx_f_q, F_MAX, press_q[0]);
         else           idx_c_d = step_idx(idx_c_q, C_MAX, press_q[0]);
      end
      frecuencia_d = freq_lut(idx_f_q);
      corriente_d  = curr_calc(idx_c_q);
      cambio_d     = (frecuencia_d != frecuencia_q) || (corriente_d != corriente_q);
   end

   // NOTE: sequential state uses <= only; the debounce counter array is small and is reset like the rest.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         stable_q     <= '0;
         press_q      <= '0;
         cnt_q        <= '0;
         idx_f_q      <= '0;
         idx_c_q      <= '0;
         control_q    <= 1'b1;
         frecuencia_q <= '0;
         corriente_q  <= '0;
         cambio_q     <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         stable_q     <= stable_d;
         press_q      <= press_d;
         cnt_q        <= cnt_d;
         idx_f_q      <= idx_f_d;
         idx_c_q      <= idx_c_d;
         control_q    <= control_d;
         frecuencia_q <= frecuencia_d;
         corriente_q  <= corriente_d;
         cambio_q     <= cambio_d;
      end
   end

   assign frecuencia = frecuencia_q;
   assign corriente  = corriente_q;
   assign control    = control_q;
   assign cambio     = cambio_q;

endmodule

// File: tb/tb_selector_consigna.sv
// Self-checking bench for selector_consigna: vector table, hand-written corner cases, random presses vs model.
module tb_selector_consigna;

   localparam int DEB_MAX = 4;
   localparam int HOLD    = 6;
   localparam int SETTLE  = 16;
`ifdef SEL_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_up = 1'b0, btn_down = 1'b0, btn_mode = 1'b0;
   logic [7:0] frecuencia;
   logic [9:0] corriente;
   logic       control, cambio;

   int n_checks = 0;
   int n_fail   = 0;

   selector_consigna #(.DEB_W(20), .DEB_MAX(DEB_MAX)) dut (
      .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_mode(btn_mode),
      .frecuencia(frecuencia), .corriente(corriente), .control(control), .cambio(cambio)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit up, dn, md;
      int f, c;
      int ctrl;
      int camb;
   } vec_t;

   vec_t vq[$];
   int   ftab[10] = '{0, 30, 50, 75, 100, 125, 150, 175, 200, 250};

   function automatic vec_t mk(bit u, bit d, bit m, int f, int c, int ctrl, int camb);
      vec_t v;
      v.up = u; v.dn = d; v.md = m; v.f = f; v.c = c; v.ctrl = ctrl; v.camb = camb;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      btn_up = 1'b0; btn_down = 1'b0; btn_mode = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // Called right after a falling edge; counts cambio pulses over the whole press window.
   task automatic apply(input bit u, input bit d, input bit m, input int hold, output int camb);
      camb = 0;
      btn_up = u; btn_down = d; btn_mode = m;
      repeat (hold) begin
         @(negedge clk);
         if (cambio) camb++;
      end
      btn_up = 1'b0; btn_down = 1'b0; btn_mode = 1'b0;
      repeat (SETTLE) begin
         @(negedge clk);
         if (cambio) camb++;
      end
   endtask

   function automatic int step_ref(int idx, int max_idx, bit up);
      if (up) return (idx == max_idx) ? (WRAP ? 0 : max_idx) : idx + 1;
      return (idx == 0) ? (WRAP ? max_idx : 0) : idx - 1;
   endfunction

   initial begin
      int camb, changes, f10, f16, f18, c22;
      int mi_f, mi_c, m_ctrl, prev_f, prev_c, hold;
      bit u, d, m;

      // Reset state and quiet hold.
      @(negedge clk);
      do_reset();
      check("reset_f", frecuencia, 0);
      check("reset_c", corriente, 0);
      check("reset_ctrl", control, 1);
      check("reset_cambio", cambio, 0);
      changes = 0;
      repeat (20) begin
         @(negedge clk);
         if (cambio || frecuencia != 0 || corriente != 0 || control != 1) changes++;
      end
      check("reset_hold_quiet", changes, 0);

      // Vector table from reset.
      for (int i = 1; i <= 9; i++) vq.push_back(mk(1, 0, 0, ftab[i], 0, 1, 1));
      f10 = WRAP ? 0 : 250;
      vq.push_back(mk(1, 0, 0, f10, 0, 1, WRAP ? 1 : 0));
      vq.push_back(mk(0, 0, 1, f10, 0, 0, 0));
      for (int k = 1; k <= 3; k++) vq.push_back(mk(1, 0, 0, f10, 50 * k, 0, 1));
      vq.push_back(mk(0, 0, 1, f10, 150, 1, 0));
      f16 = WRAP ? 250 : 200;
      vq.push_back(mk(0, 1, 0, f16, 150, 1, 1));
      vq.push_back(mk(1, 1, 0, f16, 150, 1, 0));
      f18 = WRAP ? 0 : 250;
      vq.push_back(mk(1, 0, 1, f18, 150, 0, 1));
      for (int k = 2; k >= 0; k--) vq.push_back(mk(0, 1, 0, f18, 50 * k, 0, 1));
      c22 = WRAP ? 1000 : 0;
      vq.push_back(mk(0, 1, 0, f18, c22, 0, WRAP ? 1 : 0));
      vq.push_back(mk(0, 0, 1, f18, c22, 1, 0));

      foreach (vq[i]) begin
         apply(vq[i].up, vq[i].dn, vq[i].md, HOLD, camb);
         check($sformatf("vec%0d_f", i), frecuencia, vq[i].f);
         check($sformatf("vec%0d_c", i), corriente, vq[i].c);
         check($sformatf("vec%0d_ctrl", i), control, vq[i].ctrl);
         check($sformatf("vec%0d_cambio", i), camb, vq[i].camb);
      end

      // Glitches shorter than DEB_MAX, then exact latency of a held press.
      do_reset();
      changes = 0;
      btn_up = 1'b1; repeat (2) begin @(negedge clk); if (cambio) changes++; end
      btn_up = 1'b0; repeat (2) begin @(negedge clk); if (cambio) changes++; end
      btn_up = 1'b1; repeat (3) begin @(negedge clk); if (cambio) changes++; end
      btn_up = 1'b0; repeat (SETTLE) begin @(negedge clk); if (cambio) changes++; end
      check("glitch_cambio", changes, 0);
      check("glitch_f", frecuencia, 0);
      btn_up = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == DEB_MAX + 3) check("lat_before_f", frecuencia, 0);
         if (k == DEB_MAX + 4) begin
            check("lat_edge_f", frecuencia, 30);
            check("lat_edge_cambio", cambio, 1);
         end
         if (k == DEB_MAX + 5) check("lat_after_cambio", cambio, 0);
      end
      btn_up = 1'b0;
      repeat (SETTLE) @(negedge clk);

      // Reset two cycles into a debounce: press is lost.
      apply(0, 0, 1, HOLD, camb);
      check("pre_abort_ctrl", control, 0);
      btn_up = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      btn_up = 1'b0;
      #1;
      check("abort_async_f", frecuencia, 0);
      check("abort_async_ctrl", control, 1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      changes = 0;
      repeat (20) begin @(negedge clk); if (cambio) changes++; end
      check("abort_no_update", changes, 0);
      check("abort_f", frecuencia, 0);
      check("abort_c", corriente, 0);
      check("abort_ctrl", control, 1);

      // Random presses against the reference model.
      do_reset();
      mi_f = 0; mi_c = 0; m_ctrl = 1;
      for (int n = 0; n < 60; n++) begin
         int combo;
         combo = $urandom_range(1, 7);
         u = combo[0]; d = combo[1]; m = combo[2];
         hold = $urandom_range(1, 8);
         prev_f = ftab[mi_f];
         prev_c = 50 * mi_c;
         apply(u, d, m, hold, camb);
         if (hold >= DEB_MAX) begin
            if (u != d) begin
               if (m_ctrl == 1) mi_f = step_ref(mi_f, 9, u);
               else             mi_c = step_ref(mi_c, 20, u);
            end
            if (m) m_ctrl = 1 - m_ctrl;
         end
         check($sformatf("rnd%0d_f", n), frecuencia, ftab[mi_f]);
         check($sformatf("rnd%0d_c", n), corriente, 50 * mi_c);
         check($sformatf("rnd%0d_ctrl", n), control, m_ctrl);
         check($sformatf("rnd%0d_cambio", n), camb,
               (ftab[mi_f] != prev_f || 50 * mi_c != prev_c) ? 1 : 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
